mux4_to_1: RTL and testbench

Four-input, one-output multiplexer for the 32-bit ALU datapath, used wherever one of four operands or result candidates must be chosen by a 2-bit select. It provides two outputs:
- a purely combinational output, `out`, which is the primary result;
- a registered copy with a valid flag, for pipelined consumers.

The default width is 1 bit. Bit-sliced instances build wider buses.

---
 rtl/mux_pkg.sv | 9 +
 rtl/mux4_to_1_core.sv | 27 ++
 rtl/mux4_to_1.sv | 40 ++++
 tb/tb_mux4_to_1.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - select encodings shared by the 4:1 multiplexer blocks
package mux_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux4_to_1_core.sv
// rtl/mux4_to_1_core.sv - purely combinational 4:1 selector, reusable standalone
module mux4_to_1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  // An unknown select falls through to the default and forces zero.
  always_comb begin
    out = '0;
    case (sel)
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/mux4_to_1.sv
// rtl/mux4_to_1.sv - 4:1 mux with combinational output plus registered copy and valid flag
module mux4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  mux4_to_1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .sel(sel),
    .out(out)
  );

  // out_valid marks that out_q has captured something since the last reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_q     <= out;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux4_to_1.sv
// tb/tb_mux4_to_1.sv - directed self-checking bench for mux4_to_1 at widths 1, 8 and 32
module tb_mux4_to_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  sel;

  logic        a1, b1, c1, d1, out1, out_q1, out_valid1;
  logic [7:0]  a8, b8, c8, d8, out8, out_q8;
  logic        out_valid8;
  logic [31:0] a32, b32, c32, d32, out32, out_q32;
  logic        out_valid32;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mux4_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel), .en(en),
    .out(out1), .out_q(out_q1), .out_valid(out_valid1)
  );

  mux4_to_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel), .en(en),
    .out(out8), .out_q(out_q8), .out_valid(out_valid8)
  );

  mux4_to_1 #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .c(c32), .d(d32), .sel(sel), .en(en),
    .out(out32), .out_q(out_q32), .out_valid(out_valid32)
  );

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sel = 2'b00;
    {a1, b1, c1, d1} = 4'b1111;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
    a32 = '1; b32 = '1; c32 = '1; d32 = '1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_q1, out_valid1} !== 2'b00) begin
      failed++; $display("FAIL reset_w1 got q=%b v=%b want q=0 v=0", out_q1, out_valid1);
    end
    tests++;
    if (out_q8 !== 8'h00 || out_valid8 !== 1'b0) begin
      failed++; $display("FAIL reset_w8 got q=%h v=%b want q=00 v=0", out_q8, out_valid8);
    end
    tests++;
    if (out_q32 !== 32'h0 || out_valid32 !== 1'b0) begin
      failed++; $display("FAIL reset_w32 got q=%h v=%b want q=0 v=0", out_q32, out_valid32);
    end
    tests++;
    if (out8 !== 8'hFF) begin
      failed++; $display("FAIL reset_comb_out got %h want ff", out8);
    end
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [5:0] v;
    logic       exp;
    int         errs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = i[5:0];
      {sel, d1, c1, b1, a1} = v;
      #1;
      exp = v[v[5:4]];
      tests++;
      if (out1 !== exp) begin
        failed++; errs++;
        if (errs <= 8) $display("FAIL sweep v=%b got %b want %b", v, out1, exp);
      end
    end
  endtask

  task automatic test_decode();
    logic [3:0] onehot;
    logic       exp;
    for (int h = 0; h < 4; h++) begin
      onehot = 4'b0001 << h;
      {d1, c1, b1, a1} = onehot;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        sel = s[1:0];
        #1;
        exp = (s == h);
        tests++;
        if (out1 !== exp) begin
          failed++; $display("FAIL decode hot=%0d sel=%0d got %b want %b", h, s, out1, exp);
        end
      end
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; c8 = 8'h00; d8 = 8'h00;
    sel = 2'b00; en = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_q8 !== 8'hA5 || out_valid8 !== 1'b1) begin
      failed++; $display("FAIL capture got q=%h v=%b want q=a5 v=1", out_q8, out_valid8);
    end
    @(negedge clk);
    sel = 2'b01; en = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_q8 !== 8'hA5 || out_valid8 !== 1'b1) begin
      failed++; $display("FAIL hold got q=%h v=%b want q=a5 v=1", out_q8, out_valid8);
    end
    tests++;
    if (out8 !== 8'h3C) begin
      failed++; $display("FAIL hold_comb got %h want 3c", out8);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (out_q8 !== 8'h00 || out_valid8 !== 1'b0) begin
      failed++; $display("FAIL async_reset got q=%h v=%b want q=00 v=0", out_q8, out_valid8);
    end
    tests++;
    if (out8 !== 8'h3C) begin
      failed++; $display("FAIL async_reset_comb_b got %h want 3c", out8);
    end
    sel = 2'b00;
    #1;
    tests++;
    if (out8 !== 8'hA5) begin
      failed++; $display("FAIL async_reset_comb_a got %h want a5", out8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_valid8 !== 1'b0 || out_q8 !== 8'h00) begin
      failed++; $display("FAIL idle_after_reset got q=%h v=%b want q=00 v=0", out_q8, out_valid8);
    end
    @(negedge clk);
    sel = 2'b01; en = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_q8 !== 8'h3C || out_valid8 !== 1'b1) begin
      failed++; $display("FAIL first_capture got q=%h v=%b want q=3c v=1", out_q8, out_valid8);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_unknown_sel();
    logic [1:0] s;
    @(negedge clk);
    {a1, b1, c1, d1} = 4'b1111;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
    s = 2'bx1;
    sel = s;
    #1;
    tests++;
    if ($isunknown(sel)) begin
      if (out1 !== 1'b0 || out8 !== 8'h00) begin
        failed++; $display("FAIL unknown_sel got w1=%b w8=%h want 0 and 00", out1, out8);
      end
    end else begin
      if (out1 !== 1'b1 || out8 !== 8'hFF) begin
        failed++; $display("FAIL unknown_sel_2state got w1=%b w8=%h want 1 and ff", out1, out8);
      end
    end
  endtask

  task automatic test_wide();
    logic [31:0] exp [4];
    exp[0] = 32'h0000_0001; exp[1] = 32'hFFFF_FFFF;
    exp[2] = 32'h8000_0000; exp[3] = 32'h1234_5678;
    a32 = exp[0]; b32 = exp[1]; c32 = exp[2]; d32 = exp[3];
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel = s[1:0];
      #1;
      tests++;
      if (out32 !== exp[s]) begin
        failed++; $display("FAIL wide sel=%0d got %h want %h", s, out32, exp[s]);
      end
    end
    @(negedge clk);
    sel = 2'b11; en = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_q32 !== 32'h1234_5678 || out_valid32 !== 1'b1) begin
      failed++; $display("FAIL wide_capture got q=%h v=%b want q=12345678 v=1", out_q32, out_valid32);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_decode();
    test_capture();
    test_async_reset();
    test_unknown_sel();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
